// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// selectable registered or first-word-fall-through read, and sticky error flags.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic                     r_en,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     r_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] head;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write at full is still taken when a read frees a slot in the same cycle.
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    r_data_d    = r_data_q;
    r_valid_d   = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Power-of-two depth makes the natural pointer rollover the modulo wrap.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      r_data_d = head;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (w_en && !wr_acc) overflow_d  = 1'b1;
    if (r_en && empty)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_data_q    <= r_data_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; only pointers and count say what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data  = empty ? '0 : head;
      assign r_valid = !empty;
    end else begin : g_std
      assign r_data  = r_data_q;
      assign r_valid = r_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, w_en, r_en, err_clr;
  logic [DW-1:0] w_data;

  logic [DW-1:0] r_data_s, r_data_f;
  logic          r_valid_s, r_valid_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [CW-1:0] count_s, count_f;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid, m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en), .err_clr(err_clr),
    .r_data(r_data_s), .r_valid(r_valid_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en), .err_clr(err_clr),
    .r_data(r_data_f), .r_valid(r_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    check("std.count",    32'(count_s), 32'(sz));
    check("std.full",     32'(full_s),  32'(sz == DEPTH));
    check("std.empty",    32'(empty_s), 32'(sz == 0));
    check("std.af",       32'(af_s),    32'(sz >= AF));
    check("std.ae",       32'(ae_s),    32'(sz <= AE));
    check("std.overflow", 32'(ovf_s),   32'(m_ovf));
    check("std.underflow",32'(unf_s),   32'(m_unf));
    check("std.r_valid",  32'(r_valid_s), 32'(m_rvalid));
    check("std.r_data",   32'(r_data_s),  32'(m_rdata));
    check("fw.count",     32'(count_f), 32'(sz));
    check("fw.overflow",  32'(ovf_f),   32'(m_ovf));
    check("fw.underflow", 32'(unf_f),   32'(m_unf));
    check("fw.r_valid",   32'(r_valid_f), 32'(sz != 0));
    if (sz != 0) check("fw.r_data", 32'(r_data_f), 32'(mq[0]));
  endtask

  // One clock cycle: apply inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    logic rd_ok, wr_ok;
    w_en = w; w_data = d; r_en = r; err_clr = c; rst = rs;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_rvalid = rd_ok;
      if (rd_ok) m_rdata = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; w_data = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);

    // Reset, then operations accepted right away.
    step(0, 8'h00, 0, 0, 1);

    // Fill with 0x00..0x0F, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Overflow at full, then clear.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    // Simultaneous read/write at full across pointer wrap, with set-vs-clear priority.
    for (int i = 0; i < 20; i++) step(1, 8'(8'h80 + i), 1, 0, 0);
    step(1, 8'h11, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);

    // Read from empty, then simultaneous read/write starting at empty.
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'hC0 + i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    // FWFT presentation of a single word written into empty.
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Reset mid-operation at count 7, then a 0x3C round trip.
    for (int i = 0; i < 7; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 1);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Randomized phases alternating fill-biased and drain-biased traffic.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 120; i++) begin
        logic w, r, c, rs;
        w  = ($urandom_range(99) < ((ph % 2 == 0) ? 75 : 30));
        r  = ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 75));
        c  = ($urandom_range(99) < 8);
        rs = ($urandom_range(299) == 0);
        step(w, 8'($urandom), r, c, rs);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width in bits of w_data and r_data.
REQ-002 Parameter DEPTH, default 16: number of entries; a power of two, >= 4.
REQ-003 Parameter AF_LEVEL, default 12: almost_full threshold; 1 <= AF_LEVEL <= DEPTH.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty threshold; 0 <= AE_LEVEL < DEPTH.
REQ-005 Parameter FWFT, default 0: read mode; 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: reset; synchronous, active-high.
REQ-008 Port w_en, input, 1: write request.
REQ-009 Port w_data, input, DATA_WIDTH: write data.
REQ-010 Port r_en, input, 1: read request.
REQ-011 Port err_clr, input, 1: clears the sticky error flags.
REQ-012 Port r_data, output, DATA_WIDTH: read data.
REQ-013 Port r_valid, output, 1: r_data holds valid read data.
REQ-014 Port full, output, 1: count == DEPTH.
REQ-015 Port empty, output, 1: count == 0.
REQ-016 Port almost_full, output, 1: count >= AF_LEVEL.
REQ-017 Port almost_empty, output, 1: count <= AE_LEVEL.
REQ-018 Port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-019 Port overflow, output, 1: sticky flag; a write was rejected.
REQ-020 Port underflow, output, 1: sticky flag; a read was rejected.

Function
REQ-021 The block SHALL define rd_acc = r_en && !empty, and it SHALL never bypass an empty FIFO.
REQ-022 The block SHALL define wr_acc = w_en && (!full || rd_acc).
  - At full, a simultaneous read and write SHALL both be accepted.
REQ-023 On wr_acc, the block SHALL store w_data at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-024 On rd_acc, the block SHALL advance rd_ptr modulo DEPTH; pointer wrap DEPTH-1 -> 0 SHALL be seamless.
REQ-025 The block SHALL update count on each edge:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both or neither occur.
  - count SHALL never exceed DEPTH or go below 0.
REQ-026 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count, so they change in the same cycle count changes.
REQ-027 With FWFT=0:
  - on rd_acc, r_data SHALL load the head entry at the next edge;
  - r_valid SHALL be 1 for exactly the cycle after each rd_acc;
  - r_data SHALL hold its last value otherwise.
REQ-028 With FWFT=1:
  - r_data SHALL equal the head entry whenever !empty;
  - r_valid SHALL equal !empty;
  - rd_acc consumes the displayed word;
  - the first write into an empty FIFO SHALL appear on r_data one cycle after the write edge.
REQ-029 The block SHALL set overflow at the edge after any cycle with w_en && !wr_acc.
REQ-030 The block SHALL set underflow at the edge after any cycle with r_en && empty.
REQ-031 Flag priority:
  - err_clr SHALL clear overflow and underflow at the next edge;
  - a set condition in the same cycle as err_clr SHALL win.
REQ-032 Rejected operations SHALL not alter the memory, the pointers or count.

Reset
REQ-033 While rst is sampled high, the block SHALL clear wr_ptr, rd_ptr, count, r_data, r_valid, overflow and underflow to 0 at the edge.
  - After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-034 rst SHALL take priority over all other inputs, including mid-operation; memory contents need not be cleared.
REQ-035 The block SHALL require no reset cycles beyond one; operations SHALL be accepted in the first cycle after rst deasserts.

Verification (DEPTH=16, DATA_WIDTH=8, AF_LEVEL=12, AE_LEVEL=4)
REQ-036 Fill, then drain:
  - write 0x00..0x0F on 16 consecutive cycles -> count reaches 16, full=1, almost_full rises when count=12;
  - read 16 words -> data 0x00..0x0F in order, empty=1 at the end, FWFT=0 latency exactly 1 cycle.
REQ-037 Overflow at full:
  - at full, w_en with r_en=0 -> write rejected, count stays 16, overflow=1 next cycle;
  - err_clr -> overflow=0.
REQ-038 Read from empty:
  - at empty, r_en=1 -> underflow=1, r_valid stays 0, count stays 0.
REQ-039 Simultaneous read/write at boundaries:
  - at full, simultaneous w_en and r_en for 20 cycles -> count stays 16 and the data order is preserved across pointer wrap;
  - at empty, the same stimulus -> writes accepted and reads rejected on the first cycle only.
REQ-040 FWFT=1:
  - write 0xA5 into empty -> r_data=0xA5 and r_valid=1 one cycle later, before any r_en;
  - r_en -> empty=1 next cycle.
REQ-041 Reset mid-operation:
  - assert rst at count=7 with w_en and r_en high -> next cycle count=0, empty=1, flags=0;
  - a subsequent write and read of 0x3C returns 0x3C.
